// File: rtl/pi_tustin_mc_if.sv
// Bundle of the sample handshake, gain configuration and result signals
// of pi_tustin_mc. The master side feeds samples and configuration; the
// slave side is the controller itself.
interface pi_tustin_mc_if #(
    parameter int DW   = 32,
    parameter int N_CH = 8
) ();
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                 sta;
    logic                 x_valid;
    logic signed [DW-1:0] x;
    logic                 x_ready;
    logic                 cfg_we;
    logic                 cfg_sel;
    logic [CW-1:0]        cfg_ch;
    logic signed [DW-1:0] cfg_data;
    logic                 clr_state;
    logic                 y_valid;
    logic signed [DW-1:0] y;
    logic [CW-1:0]        y_ch;
    logic                 sat_flag;
    logic                 busy;
    logic                 done_sig;

    modport master (
        output sta, x_valid, x, cfg_we, cfg_sel, cfg_ch, cfg_data, clr_state,
        input  x_ready, y_valid, y, y_ch, sat_flag, busy, done_sig
    );

    modport slave (
        input  sta, x_valid, x, cfg_we, cfg_sel, cfg_ch, cfg_data, clr_state,
        output x_ready, y_valid, y, y_ch, sat_flag, busy, done_sig
    );
endinterface

// File: rtl/pi_tustin_mc.sv
// Multi-channel Tustin PI controller: y[n] = y[n-1] + A*x[n] + B*x[n-1],
// one sample per accepted handshake, channels 0..N_CH-1 per frame, with a
// fixed 3-stage pipeline (read / multiply / sum-shift-limit).
// Optional feature macro PI_SAT_EN: clamp to [YMIN, YMAX] with sat_flag and
// anti-windup; without it the result wraps to DW bits.
module pi_tustin_mc #(
    parameter int                   DW    = 32,
    parameter int                   FRAC  = 16,
    parameter int                   N_CH  = 8,
    parameter logic signed [DW-1:0] A_DEF = DW'(64'sd1 <<< FRAC),
    parameter logic signed [DW-1:0] B_DEF = '0,
    parameter logic signed [DW-1:0] YMAX  = {1'b0, {(DW-1){1'b1}}},
    parameter logic signed [DW-1:0] YMIN  = {1'b1, {(DW-1){1'b0}}}
) (
    input logic           clk,
    input logic           rst,
    pi_tustin_mc_if.slave bus
);
    localparam int            CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int            PW      = 2 * DW;
    localparam int            SW      = 2 * DW + 2;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [1:0]    drain_q, drain_d;

    logic signed [DW-1:0] xp_q [N_CH];
    logic signed [DW-1:0] yp_q [N_CH];
    logic signed [DW-1:0] a_q  [N_CH];
    logic signed [DW-1:0] b_q  [N_CH];

    logic                 s1_vld_q, s2_vld_q;
    logic [CW-1:0]        s1_ch_q, s2_ch_q;
    logic signed [DW-1:0] s1_x_q, s1_xp_q, s1_yp_q, s1_a_q, s1_b_q;
    logic signed [DW-1:0] s2_x_q, s2_yp_q;
    logic signed [PW-1:0] s2_pa_q, s2_pb_q;
    logic signed [SW-1:0] sum_w, sh_w;
    logic signed [DW-1:0] y_res;
    logic                 sat_res;

    logic                 y_valid_q, sat_q, done_q;
    logic signed [DW-1:0] y_q;
    logic [CW-1:0]        y_ch_q;

    logic idle, accept, cfg_hit;

    assign idle        = (state_q == IDLE);
    assign accept      = (state_q == RUN) && bus.x_valid;
    assign cfg_hit     = idle && bus.cfg_we && ({1'b0, bus.cfg_ch} < (CW+1)'(N_CH));
    assign bus.x_ready = (state_q == RUN);
    assign bus.busy    = !idle;

    // FSM state, channel counter and drain counter registers
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic: start on sta, walk channels, hold 3 drain cycles
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.sta) begin
                    state_d = RUN;
                    ch_d    = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (ch_q == LAST_CH) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'd2) state_d = IDLE;
                else                 drain_d = drain_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gain tables: written only while idle, so a frame sees stable gains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                a_q[i] <= A_DEF;
                b_q[i] <= B_DEF;
            end
        end else if (cfg_hit) begin
            if (bus.cfg_sel) b_q[bus.cfg_ch] <= bus.cfg_data;
            else             a_q[bus.cfg_ch] <= bus.cfg_data;
        end
    end

    // Channel histories: cleared in idle, updated by the S3 write-back
    // NOTE: these arrays are flops rather than RAM because reset must
    // return every channel history to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                xp_q[i] <= '0;
                yp_q[i] <= '0;
            end
        end else if (idle && bus.clr_state) begin
            for (int i = 0; i < N_CH; i++) begin
                xp_q[i] <= '0;
                yp_q[i] <= '0;
            end
        end else if (s2_vld_q) begin
            xp_q[s2_ch_q] <= s2_x_q;
            yp_q[s2_ch_q] <= y_res;
        end
    end

    // S1: capture the sample with its channel history and gains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0;
            s1_ch_q  <= '0;
            s1_x_q   <= '0;
            s1_xp_q  <= '0;
            s1_yp_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_ch_q <= ch_q;
                s1_x_q  <= bus.x;
                s1_xp_q <= xp_q[ch_q];
                s1_yp_q <= yp_q[ch_q];
                s1_a_q  <= a_q[ch_q];
                s1_b_q  <= b_q[ch_q];
            end
        end
    end

    // S2: full-width signed products
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q <= 1'b0;
            s2_ch_q  <= '0;
            s2_x_q   <= '0;
            s2_yp_q  <= '0;
            s2_pa_q  <= '0;
            s2_pb_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            s2_ch_q  <= s1_ch_q;
            s2_x_q   <= s1_x_q;
            s2_yp_q  <= s1_yp_q;
            s2_pa_q  <= PW'(s1_a_q) * PW'(s1_x_q);
            s2_pb_q  <= PW'(s1_b_q) * PW'(s1_xp_q);
        end
    end

    // Two guard bits above the product width keep the three-term sum exact;
    // the arithmetic shift floors toward minus infinity.
    assign sum_w = (SW'(s2_yp_q) <<< FRAC) + SW'(s2_pa_q) + SW'(s2_pb_q);
    assign sh_w  = sum_w >>> FRAC;

`ifdef PI_SAT_EN
    // S3 limit: clamp to [YMIN, YMAX]; the clamped value feeds the history
    always_comb begin
        y_res   = sh_w[DW-1:0];
        sat_res = 1'b0;
        if (sh_w > SW'(YMAX)) begin
            y_res   = YMAX;
            sat_res = 1'b1;
        end else if (sh_w < SW'(YMIN)) begin
            y_res   = YMIN;
            sat_res = 1'b1;
        end
    end
`else
    // Two's-complement wrap: the limits and upper sum bits are not needed
    logic unused_wrap;
    assign unused_wrap = ^{sh_w[SW-1:DW], YMAX, YMIN};
    assign y_res       = sh_w[DW-1:0];
    assign sat_res     = 1'b0;
`endif

    // S3 output register, with done marking the last channel of a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_valid_q <= 1'b0;
            y_q       <= '0;
            y_ch_q    <= '0;
            sat_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            y_valid_q <= s2_vld_q;
            done_q    <= s2_vld_q && (s2_ch_q == LAST_CH);
            if (s2_vld_q) begin
                y_q    <= y_res;
                y_ch_q <= s2_ch_q;
                sat_q  <= sat_res;
            end
        end
    end

    assign bus.y_valid  = y_valid_q;
    assign bus.y        = y_q;
    assign bus.y_ch     = y_ch_q;
    assign bus.sat_flag = sat_q;
    assign bus.done_sig = done_q;
endmodule

// File: tb/tb_pi_tustin_mc.sv
// Directed bench for pi_tustin_mc (DW=32, FRAC=16, N_CH=4, YMAX=1.5).
// Expected y values are hand-computed in Q16 in the vector table; builds
// with PI_SAT_EN select the clamped column.
`timescale 1ns/1ps
module tb_pi_tustin_mc;
    localparam int DW   = 32;
    localparam int FRAC = 16;
    localparam int N_CH = 4;
    localparam int CW   = 2;
    localparam int ONE  = 65536;
    localparam int NV   = 38;

    typedef struct {
        int x;
        int y_wrap;
        int y_sat;
        bit sat;
    } vec_t;

    typedef struct {
        int due;
        int ch;
        int y;
        bit sat;
        bit done;
    } exp_t;

    logic   clk;
    logic   rst;
    int     checks = 0;
    int     fails  = 0;
    int     cyc    = 0;
    vec_t   vt [NV];
    exp_t   exp_q [$];

    pi_tustin_mc_if #(.DW(DW), .N_CH(N_CH)) bus ();

    pi_tustin_mc #(
        .DW(DW), .FRAC(FRAC), .N_CH(N_CH), .YMAX(32'sd98304)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic int exp_y(input int i);
`ifdef PI_SAT_EN
        return vt[i].y_sat;
`else
        return vt[i].y_wrap;
`endif
    endfunction

    function automatic bit exp_sat(input int i);
`ifdef PI_SAT_EN
        return vt[i].sat;
`else
        return 1'b0;
`endif
    endfunction

    // Result monitor: each y_valid must match the oldest outstanding accept
    always @(negedge clk) begin
        exp_t e;
        if (bus.y_valid) begin
            if (exp_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL spurious_y_valid: y_valid=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("y_latency", cyc, e.due);
                check("y_ch", bus.y_ch, e.ch);
                check("y", bus.y, e.y);
                check("sat_flag", bus.sat_flag, e.sat);
                check("done_sig", bus.done_sig, e.done);
            end
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checks++; fails++;
                $display("FAIL missing_y: no y_valid for ch %0d due at cycle %0d", exp_q[0].ch, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (bus.done_sig) begin
                checks++; fails++;
                $display("FAIL stray_done: done_sig=1 without y_valid (cycle %0d)", cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        check({tag, "_y_valid"}, bus.y_valid, 0);
        check({tag, "_y"}, bus.y, 0);
        check({tag, "_y_ch"}, bus.y_ch, 0);
        check({tag, "_sat_flag"}, bus.sat_flag, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done_sig"}, bus.done_sig, 0);
        check({tag, "_x_ready"}, bus.x_ready, 0);
    endtask

    task automatic cfg_write(input bit sel, input logic [CW-1:0] ch, input int data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_ch   = ch;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic clr_pulse();
        bus.clr_state = 1'b1;
        tick();
        bus.clr_state = 1'b0;
    endtask

    // Offer one sample and wait (bounded) for it to be accepted
    task automatic send(input int vi, input int ch);
        bit ok;
        ok = 1'b0;
        bus.x_valid = 1'b1;
        bus.x       = vt[vi].x;
        for (int t = 0; t < 8 && !ok; t++) begin
            @(negedge clk);
            if (bus.x_ready) begin
                ok = 1'b1;
                exp_q.push_back('{cyc + 3, ch, exp_y(vi), exp_sat(vi), (ch == N_CH - 1)});
            end
            tick();
        end
        bus.x_valid = 1'b0;
        check("x_accepted", ok, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 12 && exp_q.size() != 0; t++) tick();
        check("outstanding_after_frame", exp_q.size(), 0);
        check("busy_after_frame", bus.busy, 0);
    endtask

    // One full frame; optional 2-cycle stall before channel stall_ch, with
    // sta / cfg_we / clr_state poked during the stall (all must be ignored)
    task automatic run_frame(input int base, input int stall_ch, input bit poke);
        bus.sta = 1'b1;
        tick();
        bus.sta       = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.clr_state = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (k == stall_ch) begin
                bus.x_valid = 1'b0;
                if (poke) begin
                    bus.sta       = 1'b1;
                    bus.cfg_we    = 1'b1;
                    bus.cfg_sel   = 1'b0;
                    bus.cfg_ch    = 2'd2;
                    bus.cfg_data  = 0;
                    bus.clr_state = 1'b1;
                end
                tick();
                bus.sta       = 1'b0;
                bus.cfg_we    = 1'b0;
                bus.clr_state = 1'b0;
                tick();
            end
            send(base + k, k);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NV; i++) vt[i] = '{0, 0, 0, 1'b0};
        // Frame pair at A=1, B=0: accumulation, second frame with stall
        vt[0]  = '{ONE,        ONE,        ONE,         1'b0};
        vt[1]  = '{2*ONE,      2*ONE,      3*ONE/2,     1'b1};
        vt[2]  = '{-ONE,       -ONE,       -ONE,        1'b0};
        vt[4]  = '{ONE,        2*ONE,      3*ONE/2,     1'b1};
        vt[5]  = '{2*ONE,      4*ONE,      3*ONE/2,     1'b1};
        vt[6]  = '{-ONE,       -2*ONE,     -2*ONE,      1'b0};
        // A0=0.5, B0=-0.25; A1=0.5 on x=-1 LSB floors to -1
        vt[8]  = '{ONE,        ONE/2,      ONE/2,       1'b0};
        vt[9]  = '{-1,         -1,         -1,          1'b0};
        vt[12] = '{ONE,        3*ONE/4,    3*ONE/4,     1'b0};
        vt[13] = '{0,          -1,         -1,          1'b0};
        // Saturation run on ch 0
        vt[16] = '{ONE,        ONE,        ONE,         1'b0};
        vt[20] = '{ONE,        2*ONE,      3*ONE/2,     1'b1};
        vt[24] = '{ONE,        3*ONE,      3*ONE/2,     1'b1};
        // clr_state together with sta
        vt[28] = '{ONE/4,      ONE/4,      ONE/4,       1'b0};
        vt[29] = '{-2*ONE,     -2*ONE,     -2*ONE,      1'b0};
        // Aborted frame, then a frame after reset
        vt[32] = '{ONE,        0,          0,           1'b0};
        vt[33] = '{ONE,        0,          0,           1'b0};
        vt[34] = '{ONE,        ONE,        ONE,         1'b0};
        vt[35] = '{-3*ONE/4,   -3*ONE/4,   -3*ONE/4,    1'b0};
        vt[36] = '{ONE/2,      ONE/2,      ONE/2,       1'b0};
        vt[37] = '{ONE,        ONE,        ONE,         1'b0};

        rst           = 1'b0;
        bus.sta       = 1'b0;
        bus.x_valid   = 1'b0;
        bus.x         = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_data  = '0;
        bus.clr_state = 1'b0;
        tick();
        check_zero("reset");
        tick();
        rst = 1'b1;
        tick();

        run_frame(0, -1, 1'b0);
        run_frame(4, 2, 1'b1);

        clr_pulse();
        cfg_write(1'b0, 2'd0, ONE/2);
        cfg_write(1'b1, 2'd0, -ONE/4);
        cfg_write(1'b0, 2'd1, ONE/2);
        run_frame(8, -1, 1'b0);
        run_frame(12, -1, 1'b0);

        clr_pulse();
        cfg_write(1'b1, 2'd0, 0);
        cfg_write(1'b0, 2'd1, ONE);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = 1'b0;
        bus.cfg_ch   = 2'd0;
        bus.cfg_data = ONE;
        run_frame(16, -1, 1'b0);
        run_frame(20, -1, 1'b0);
        run_frame(24, -1, 1'b0);

        bus.clr_state = 1'b1;
        run_frame(28, -1, 1'b0);

        cfg_write(1'b0, 2'd0, 2*ONE);
        cfg_write(1'b1, 2'd1, ONE/2);
        bus.sta = 1'b1;
        tick();
        bus.sta = 1'b0;
        send(32, 0);
        send(33, 1);
        bus.x_valid = 1'b1;
        bus.x       = ONE;
        #1 rst = 1'b0;
        exp_q.delete();
        check_zero("midrun_reset");
        bus.x_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        run_frame(34, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/pi_tustin_mc.md
PI_TUSTIN_MC -- requirements
Module: pi_tustin_mc

Interface
REQ-001 SHALL have parameter DW, default 32: signed fixed-point sample width.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits of x, y and gains.
REQ-003 SHALL have parameter N_CH, default 8: channel count, legal range 1..256.
REQ-004 SHALL have parameters A_DEF, default 1.0 in Q(FRAC), and B_DEF, default 0: reset gains for every channel.
REQ-005 SHALL have parameters YMAX, default +2^(DW-1)-1, and YMIN, default -2^(DW-1): saturation limits.
REQ-006 SHALL have ports as follows:
- clk  in  1  clock; the single clock domain.
- rst  in  1  reset; asynchronous, active-low.
- sta  in  1  frame start pulse.
- x_valid  in  1  sample valid.
- x  in  DW  signed sample for the current channel.
- x_ready  out  1  sample accepted when x_valid is also 1.
- cfg_we  in  1  gain write strobe.
- cfg_sel  in  1  gain select: 0 = A, 1 = B.
- cfg_ch  in  clog2(N_CH)  target channel of the gain write.
- cfg_data  in  DW  gain value in Q(FRAC).
- clr_state  in  1  pulse that zeroes all channel histories.
- y_valid  out  1  output valid.
- y  out  DW  signed result.
- y_ch  out  clog2(N_CH)  channel of y.
- sat_flag  out  1  y was clamped.
- busy  out  1  high in RUN and DRAIN.
- done_sig  out  1  one-cycle pulse with the last y of a frame.

Function
REQ-007 SHALL compute, per channel c: y[n] = y[n-1] + A[c]*x[n] + B[c]*x[n-1] (Tustin form of Kp + Ki/s). Per-channel x_prev, y_prev, A and B SHALL be held in internal arrays.
REQ-008 SHALL implement the FSM states IDLE, RUN and DRAIN with these transitions:
- IDLE to RUN on sta; the channel counter clears to 0.
- RUN to DRAIN on accepting the sample for channel N_CH-1.
- DRAIN to IDLE after 3 cycles.
REQ-009 SHALL assert x_ready only in RUN. Channels are consumed in order 0..N_CH-1, one per accepted handshake; stall cycles (x_valid = 0) are allowed.
REQ-010 SHALL ignore sta while in RUN or DRAIN. A new frame SHALL therefore never overlap a previous frame's write-back.
REQ-011 SHALL use a 3-stage pipeline, so y_valid is high exactly 3 cycles after the accept cycle:
- S1 registers x, c and the state and gain reads.
- S2 registers full 2*DW-bit signed products.
- S3 sums (y_prev<<FRAC) + A*x + B*x_prev at 2*DW+2 bits, arithmetic-shifts right by FRAC (truncation toward minus infinity), limits the result to DW, then registers it.
REQ-012 SHALL write x to x_prev[c] and the final y to y_prev[c] in the S3 cycle.
REQ-013 SHALL assert done_sig together with y_valid for channel N_CH-1, i.e. on the last DRAIN cycle.
REQ-014 SHALL apply cfg_we in IDLE only, writing cfg_data to A[cfg_ch] or B[cfg_ch]. It SHALL be ignored in RUN or DRAIN, and when cfg_ch >= N_CH.
REQ-015 SHALL zero every x_prev and y_prev on clr_state in IDLE. clr_state SHALL be ignored in RUN or DRAIN. When clr_state and sta arrive in the same IDLE cycle, the clear SHALL apply first and the frame SHALL then start.
REQ-016 SHALL apply cfg_we before sta when both arrive in the same IDLE cycle.

Reset
REQ-017 SHALL set on rst low, asynchronously:
- FSM to IDLE and channel counter to 0.
- All pipeline valid bits to 0.
- y, y_ch, y_valid, sat_flag, busy, done_sig and x_ready to 0.
- All x_prev and y_prev to 0.
- All A to A_DEF and all B to B_DEF.
REQ-018 SHALL discard an in-flight frame on reset mid-operation, with no further y_valid.

Configuration
REQ-019 SHALL honour macro PI_SAT_EN as follows:
- Defined: S3 clamps to [YMIN, YMAX] and sets sat_flag for that sample. The clamped value is what gets stored in y_prev (anti-windup).
- Undefined: S3 keeps the low DW bits (two's-complement wrap), and sat_flag is tied to 0.

Verification
REQ-020 SHALL pass scenario: N_CH=4, A=1.0, B=0; frame x={1.0, 2.0, -1.0, 0} run twice -> second frame y={2.0, 4.0, -2.0, 0}. y_valid 3 cycles after each accept; done_sig with ch 3.
REQ-021 SHALL pass scenario: A=0.5, B=-0.25 on ch 0; x=1.0 then 1.0 across two frames -> y=0.5 then 0.75.
REQ-022 SHALL pass scenario: x_valid low for 2 cycles mid-frame -> channel order kept, each y exactly 3 cycles after its accept; sta pulsed during RUN is ignored.
REQ-023 SHALL pass scenario: PI_SAT_EN, YMAX=1.5, A=1.0, x=1.0 for 3 frames -> y=1.0, 1.5 (sat_flag=1), 1.5 (sat_flag=1). Without the macro the third y is 3.0.
REQ-024 SHALL pass scenario: rst low during RUN at channel 2, then release, then a frame with A=A_DEF -> outputs 0 during reset and y equal to A_DEF*x with zero history.
REQ-025 SHALL pass scenario: clr_state and sta in the same IDLE cycle after a nonzero history -> first y equals A*x only.
